// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and helpers for the memory port arbiter.
// Provides the FSM state enum, access size enum, misalignment check and byte-lane mask.
package mem_arb_pkg;
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;
  function automatic logic misalign(size_t s, logic [2:0] a);
    return s == SZ_H ? a[0] : s == SZ_W ? |a[1:0] : s == SZ_D ? |a : 1'b0;
  endfunction
  function automatic logic [7:0] lane_mask(size_t s, logic [2:0] off);
    return (s == SZ_B ? 8'h01 : s == SZ_H ? 8'h03 : s == SZ_W ? 8'h0f : 8'hff) << off;
  endfunction
endpackage

// File: rtl/mem_lane_unit.sv
// mem_lane_unit: byte-lane store merge and load extract/extend on one doubleword.
// Ports: old (memory doubleword), wdata (right-aligned store data), size, off (byte offset),
//        uns (zero-extend), merged (old with store lanes replaced), loaded (extended field).
module mem_lane_unit
  import mem_arb_pkg::*;
(
  input  logic [63:0] old,
  input  logic [63:0] wdata,
  input  size_t       size,
  input  logic [2:0]  off,
  input  logic        uns,
  output logic [63:0] merged,
  output logic [63:0] loaded
);
  logic [7:0] m;
  logic [63:0] bm, sh;
  always_comb begin
    m = lane_mask(size, off);
    for (int i = 0; i < 8; i++) bm[i*8 +: 8] = {8{m[i]}};
    merged = ((wdata << {off, 3'b000}) & bm) | (old & ~bm);
    sh = old >> {off, 3'b000};
    loaded = size == SZ_B ? {{56{~uns & sh[7]}}, sh[7:0]} :
             size == SZ_H ? {{48{~uns & sh[15]}}, sh[15:0]} :
             size == SZ_W ? {{32{~uns & sh[31]}}, sh[31:0]} : sh;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequences the shared single-port data memory for fetch and load/store.
// Ports: f_* fetch request/response, d_* data request/response, mem_* memory macro side,
//        busy high outside IDLE. Data wins over fetch; all outputs are registered.
module mem_port_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [63:0] f_addr,
  output logic        f_ack,
  output logic [31:0] f_instr,
  output logic        f_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_uns,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_ack,
  output logic [63:0] d_rdata,
  output logic        d_err,
  output logic [63:0] mem_addr,
  output logic        mem_wr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        busy
);
  state_t state, state_n;
  size_t size, size_n;
  logic gnt_d, gnt_n, we, we_n, uns, uns_n, resp, err, mw_n;
  logic [63:0] addr, addr_n, wdata, wdata_n, ma_n, mwd_n, dr_n, merged, loaded;
  logic [31:0] fi_n;
  mem_lane_unit lanes (
    .old(mem_rdata), .wdata(wdata), .size(size), .off(addr[2:0]), .uns(uns),
    .merged(merged), .loaded(loaded)
  );
  always_comb begin
    state_n = state;
    gnt_n = gnt_d;
    addr_n = addr;
    size_n = size;
    we_n = we;
    uns_n = uns;
    wdata_n = wdata;
    ma_n = mem_addr;
    mw_n = 1'b0;
    mwd_n = mem_wdata;
    fi_n = f_instr;
    dr_n = d_rdata;
    resp = 1'b0;
    err = 1'b0;
    case (state)
      IDLE: if (d_req || f_req) begin
        gnt_n = d_req;
        addr_n = d_req ? d_addr : f_addr;
        size_n = d_req ? size_t'(d_size) : SZ_W;
        we_n = d_req & d_we;
        uns_n = d_uns;
        wdata_n = d_wdata;
        err = misalign(size_n, addr_n[2:0]);
        resp = err;
        mw_n = !err && we_n && size_n == SZ_D;
        state_n = err ? RESP : mw_n ? WR : RD;
        ma_n = err ? mem_addr : {addr_n[63:3], 3'b000};
        mwd_n = mw_n ? d_wdata : mem_wdata;
      end
      RD: state_n = CAP;
      CAP: begin
        state_n = we ? WR : RESP;
        mw_n = we;
        mwd_n = we ? merged : mem_wdata;
        resp = !we;
        fi_n = we || gnt_d ? f_instr : addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
        dr_n = !we && gnt_d ? loaded : d_rdata;
      end
      WR: begin
        state_n = RESP;
        resp = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gnt_d <= 1'b0;
      addr <= '0;
      size <= SZ_B;
      we <= 1'b0;
      uns <= 1'b0;
      wdata <= '0;
      f_ack <= 1'b0;
      d_ack <= 1'b0;
      f_err <= 1'b0;
      d_err <= 1'b0;
      f_instr <= '0;
      d_rdata <= '0;
      mem_addr <= '0;
      mem_wr <= 1'b0;
      mem_wdata <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      gnt_d <= gnt_n;
      addr <= addr_n;
      size <= size_n;
      we <= we_n;
      uns <= uns_n;
      wdata <= wdata_n;
      f_ack <= resp & ~gnt_n;
      d_ack <= resp & gnt_n;
      f_err <= resp & ~gnt_n & err;
      d_err <= resp & gnt_n & err;
      f_instr <= fi_n;
      d_rdata <= dr_n;
      mem_addr <= ma_n;
      mem_wr <= mw_n;
      mem_wdata <= mwd_n;
      busy <= state_n != IDLE;
    end
  end
endmodule
